adc_capture_sequencer: RTL and testbench
========================================

# adc_capture_sequencer

Sequences the oscilloscope datapath: samples the 8-bit ADC bus at a programmable decimated rate, waits for an edge trigger, captures a fixed-depth frame into on-chip RAM, then streams the frame out through the existing UART transmitter. It sits between the ADC input pins and the `uart` instance. It replaces the free-running one-sample-per-interval sender with triggered, gap-free frame capture.

## Interface
- `DEPTH`, 256: samples per frame; power of two, 16..4096.
- `ADDR_W`, 8: log2(`DEPTH`).
- `DECIM_W`, 16: width of the decimation control.
- `HDR_BYTE`, 8'hA5: frame header value.

- `clk` in 1: system clock (27 MHz).
- `rst_n` in 1: synchronous, active-low reset.
- `adc_in` in 8: ADC sample bus, MSB is bit 7.
- `arm` in 1: one-cycle pulse; starts a capture when in IDLE.
- `force_trig` in 1: level; trigger on the next sample tick while in WAIT_TRIG.
- `trig_level` in 8: trigger threshold, unsigned.
- `trig_rising` in 1: 1 = rising-edge trigger, 0 = falling-edge trigger.
- `decim` in `DECIM_W`: a sample tick occurs every `decim`+1 clocks.
- `tx_busy` in 1: UART transmitter busy.
- `tx_data` out 8: byte presented to the UART.
- `tx_send_n` out 1: active-low one-cycle send strobe to the UART.
- `state` out 3: current state encoding (IDLE=0, WAIT_TRIG=1, CAPTURE=2, SEND_HDR=3, SEND=4).
- `frame_done` out 1: one-cycle pulse after the last byte of a frame is accepted.

## Operation
- Decimation counter counts 0..`decim`; a tick is asserted on terminal count. The counter runs continuously in every state except IDLE, where it is held at 0.
- On each tick, `adc_in` is registered into `cur`, and the old `cur` moves into `prev`. `prev` is invalid until the second tick after leaving IDLE; no trigger can fire before `prev` is valid.
- Trigger conditions:
  - Rising: `prev < trig_level && cur >= trig_level`.
  - Falling: `prev >= trig_level && cur < trig_level`.
  - `force_trig` overrides both, but still qualifies on a tick.
- State transitions:
  - IDLE: `arm` → WAIT_TRIG. `arm` is ignored in every other state.
  - WAIT_TRIG: trigger → CAPTURE. The triggering sample `cur` is written to address 0.
  - CAPTURE: each tick writes `cur` to the write address and increments it. The write of address `DEPTH`-1 → SEND_HDR (or SEND if the header is compiled out). The write address wraps to 0.
  - SEND_HDR: issue `HDR_BYTE` → SEND.
  - SEND: read addresses 0..`DEPTH`-1 in order, one byte per UART transaction. After the last byte is accepted, pulse `frame_done` → IDLE.
- UART handshake:
  - `tx_send_n` goes low only when `tx_busy`=0 and the byte is valid on `tx_data` in the same cycle.
  - After a strobe, `tx_busy` is ignored for 2 cycles (UART register latency). The next strobe waits for `tx_busy`=0.
  - `tx_data` is held stable from the strobe until the next strobe.
- Sample RAM: single-port, `DEPTH`×8, synchronous read with 1-cycle latency. Reads occur only in SEND and writes only in CAPTURE, so there is no port conflict.
- Changes to `decim`, `trig_level` and `trig_rising` take effect immediately. They are not shadowed.

## Timing
- Reset values:
  - `tx_send_n`=1, `tx_data`=0, `state`=IDLE, `frame_done`=0.
  - Counters, `prev` and `cur` = 0; `prev` is marked invalid.
- `rst_n` low in any state returns the block to IDLE on the next edge and drops any partial frame. RAM contents are not cleared.
- `arm` → WAIT_TRIG: 1 clock.
- Trigger tick → first RAM write: the same edge.
- CAPTURE duration: exactly (`DEPTH`-1) further ticks.
- SEND: RAM read is issued 1 cycle before `tx_data` is loaded. With an idle UART, the strobe follows 2 cycles after entering SEND.
- `frame_done`: 1 cycle after the final strobe's busy period ends, coincident with the return to IDLE.
- `decim`=0: a tick every clock, so capture runs at full clock rate.

## Configuration
- `ADC_CAPTURE_HEADER_EN` defined: each frame is `HDR_BYTE` followed by `DEPTH` samples, giving `DEPTH`+1 strobes.
- Not defined: the SEND_HDR state is removed. Each frame is `DEPTH` samples, CAPTURE goes directly to SEND, and `state` never reads 3.

## Test plan
- Rising trigger:
  - Stimulus: `decim`=0, `trig_level`=128, ramp `adc_in` 100,110,…; pulse `arm`.
  - Required: the first captured byte is the first sample ≥128 whose previous sample was <128; `DEPTH` (+1 with header) strobes; `frame_done` pulses once.
- Falling trigger with decimation:
  - Stimulus: `decim`=3, `trig_rising`=0, step `adc_in` from 200 to 50.
  - Required: samples are taken every 4 clocks; the captured sequence is 50, 50, …; no trigger occurs before the second tick.
- `force_trig`:
  - Stimulus: constant `adc_in`=0x3C, `force_trig`=1.
  - Required: capture starts on the second tick; all `DEPTH` bytes are 0x3C; header 0xA5 is first when `ADC_CAPTURE_HEADER_EN` is set.
- Backpressure:
  - Stimulus: `tx_busy` held high for 100 cycles after each strobe.
  - Required: exactly one strobe per busy-low window; no byte is lost or repeated; `tx_data` is stable between strobes.
- Reset mid-frame:
  - Stimulus: assert `rst_n`=0 during SEND at byte 10, release, then re-arm.
  - Required: `state`=0 and `tx_send_n`=1 the cycle after the reset edge; the new frame starts from address 0.
- `arm` while busy:
  - Stimulus: pulse `arm` during CAPTURE and during SEND.
  - Required: no state change; frame length is unchanged.

Source files
------------

// File: rtl/adc_capture_sequencer.sv
// Decimated ADC sampler with edge trigger, DEPTH-sample frame capture into RAM and
// UART byte streaming. Define ADC_CAPTURE_HEADER_EN to prefix each frame with HDR_BYTE.
module adc_capture_sequencer #(
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DECIM_W  = 16,
    parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         adc_in,
    input  logic               arm,
    input  logic               force_trig,
    input  logic [7:0]         trig_level,
    input  logic               trig_rising,
    input  logic [DECIM_W-1:0] decim,
    input  logic               tx_busy,
    output logic [7:0]         tx_data,
    output logic               tx_send_n,
    output logic [2:0]         state,
    output logic               frame_done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_CAPT = 3'd2,
`ifdef ADC_CAPTURE_HEADER_EN
        S_HDR  = 3'd3,
`endif
        S_SEND = 3'd4
    } state_t;

    state_t             st;
    logic [DECIM_W-1:0] cnt;
    logic [7:0]         cur;
    logic               cur_valid;
    logic [ADDR_W-1:0]  waddr;
    logic [ADDR_W-1:0]  raddr;
    logic [1:0]         hold;
    logic               fin;
    logic [7:0]         ram_q;
    logic [7:0]         mem [DEPTH];

    logic               tick;
    logic               hit;
    logic               tx_ready;
    logic               we;
    logic [ADDR_W-1:0]  wa;
    logic               hdr_sel;
    logic [7:0]         next_byte;

`ifdef ADC_CAPTURE_HEADER_EN
    assign hdr_sel = (st == S_HDR);
`else
    assign hdr_sel = 1'b0;
`endif
    assign next_byte = hdr_sel ? HDR_BYTE : ram_q;
    assign state     = st;

    // The trigger is judged on the edge that registers adc_in, so the old cur acts as prev
    // and cur_valid means prev will be valid once this sample lands.
    always_comb begin
        tick = (st != S_IDLE) && (cnt >= decim);
        hit  = 1'b0;
        if (tick && cur_valid) begin
            if (force_trig)
                hit = 1'b1;
            else if (trig_rising)
                hit = (cur < trig_level) && (adc_in >= trig_level);
            else
                hit = (cur >= trig_level) && (adc_in < trig_level);
        end
        tx_ready = (hold == 2'd0) && !tx_busy;
        we       = ((st == S_WAIT) && hit) || ((st == S_CAPT) && tick);
        wa       = (st == S_CAPT) ? waddr : '0;
    end

    always_ff @(posedge clk) begin
        if (we && rst_n)
            mem[wa] <= adc_in;
        if (st == S_SEND)
            ram_q <= mem[raddr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st         <= S_IDLE;
            cnt        <= '0;
            cur        <= '0;
            cur_valid  <= 1'b0;
            waddr      <= '0;
            raddr      <= '0;
            hold       <= '0;
            fin        <= 1'b0;
            tx_data    <= '0;
            tx_send_n  <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            tx_send_n  <= 1'b1;
            frame_done <= 1'b0;
            if (hold != 2'd0)
                hold <= hold - 2'd1;

            if (st == S_IDLE || tick)
                cnt <= '0;
            else
                cnt <= cnt + DECIM_W'(1);

            if (st == S_IDLE) begin
                cur_valid <= 1'b0;
            end else if (tick) begin
                cur       <= adc_in;
                cur_valid <= 1'b1;
            end

            case (st)
                S_IDLE: if (arm) st <= S_WAIT;
                S_WAIT: if (hit) begin
                    st    <= S_CAPT;
                    waddr <= ADDR_W'(1);
                end
                S_CAPT: if (tick) begin
                    waddr <= waddr + ADDR_W'(1);
                    if (waddr == ADDR_W'(DEPTH - 1)) begin
                        raddr <= '0;
                        fin   <= 1'b0;
`ifdef ADC_CAPTURE_HEADER_EN
                        st    <= S_HDR;
`else
                        st    <= S_SEND;
                        hold  <= 2'd1;
`endif
                    end
                end
`ifdef ADC_CAPTURE_HEADER_EN
                S_HDR: if (tx_ready) begin
                    tx_data   <= next_byte;
                    tx_send_n <= 1'b0;
                    hold      <= 2'd3;
                    st        <= S_SEND;
                end
`endif
                // hold covers the UART busy latency and the RAM read of the next address
                S_SEND: if (tx_ready) begin
                    if (fin) begin
                        frame_done <= 1'b1;
                        st         <= S_IDLE;
                    end else begin
                        tx_data   <= next_byte;
                        tx_send_n <= 1'b0;
                        hold      <= 2'd3;
                        if (raddr == ADDR_W'(DEPTH - 1))
                            fin <= 1'b1;
                        else
                            raddr <= raddr + ADDR_W'(1);
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Randomized scoreboard bench for adc_capture_sequencer: expected frames come from the
// recorded sample stream; a monitor checks every strobed byte against the queue.
module tb_adc_capture_sequencer;
    localparam int unsigned DEPTH  = 16;
    localparam logic [7:0]  HDR    = 8'hA5;
`ifdef ADC_CAPTURE_HEADER_EN
    localparam bit          HDR_ON = 1'b1;
`else
    localparam bit          HDR_ON = 1'b0;
`endif
    localparam int unsigned FRAME_LEN = DEPTH + (HDR_ON ? 1 : 0);
    localparam int unsigned BUDGET    = 6000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  adc_in;
    logic        arm;
    logic        force_trig;
    logic [7:0]  trig_level;
    logic        trig_rising;
    logic [15:0] decim;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        tx_send_n;
    logic [2:0]  state;
    logic        frame_done;

    always #5 clk = ~clk;

    adc_capture_sequencer #(
        .DEPTH   (DEPTH),
        .ADDR_W  (4),
        .DECIM_W (16),
        .HDR_BYTE(HDR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .adc_in     (adc_in),
        .arm        (arm),
        .force_trig (force_trig),
        .trig_level (trig_level),
        .trig_rising(trig_rising),
        .decim      (decim),
        .tx_busy    (tx_busy),
        .tx_data    (tx_data),
        .tx_send_n  (tx_send_n),
        .state      (state),
        .frame_done (frame_done)
    );

    int          total = 0;
    int          bad = 0;
    logic [7:0]  exp_q[$];
    int unsigned n_strobe = 0;
    int unsigned frames_done = 0;
    int unsigned bp_len = 0;
    logic [7:0]  last_byte = '0;
    bit          has_last = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit fires(bit frc, bit rise, logic [7:0] lvl, logic [7:0] p, logic [7:0] c);
        if (frc)
            return 1'b1;
        return rise ? (p < lvl && c >= lvl) : (p >= lvl && c < lvl);
    endfunction

    // pat 0: ramp +10 per sample, 1: step 200 -> 50, 2: constant 0x3C, else random per clock
    function automatic logic [7:0] pattern(int pat, int unsigned j, int unsigned dec);
        int unsigned n;
        n = j / (dec + 1);
        case (pat)
            0:       return 8'(100 + 10 * n);
            1:       return (n < 3) ? 8'd200 : 8'd50;
            2:       return 8'h3C;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // Monitor: compares each strobed byte, byte stability and frame length.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                has_last = 1'b0;
            end else begin
                if (!tx_send_n) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_byte: got %0h expected none at %0t", tx_data, $time);
                    end else begin
                        check("tx_byte", tx_data, exp_q.pop_front());
                    end
                    n_strobe++;
                    last_byte = tx_data;
                    has_last  = 1'b1;
                end else if (has_last) begin
                    check("tx_hold", tx_data, last_byte);
                end
                if (frame_done) begin
                    check("frame_len", n_strobe, FRAME_LEN);
                    check("queue_drained", exp_q.size(), 0);
                    frames_done++;
                    n_strobe = 0;
                end
            end
        end
    end

    // UART model: busy rises two cycles after a strobe and stays high bp_len cycles.
    initial begin
        int unsigned dly;
        int unsigned rem;
        bit          active;
        dly = 0;
        rem = 0;
        active = 1'b0;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!tx_send_n) begin
                total++;
                if (active) begin
                    bad++;
                    $display("FAIL strobe_in_busy: got strobe expected none at %0t", $time);
                end
                active = 1'b1;
                dly    = 1;
                rem    = bp_len;
            end else if (active) begin
                if (dly > 0) begin
                    dly--;
                end else if (rem > 0) begin
                    tx_busy = 1'b1;
                    rem--;
                end else begin
                    tx_busy = 1'b0;
                    active  = 1'b0;
                end
            end
        end
    end

    task automatic run_frame(input int unsigned dec, input logic [7:0] lvl, input bit rise,
                             input int pat, input int unsigned bp, input bit poke,
                             input int unsigned rst_at);
        logic [7:0]  smp[$];
        logic [7:0]  v;
        bit          trig;
        bit          frc;
        int unsigned got;
        int unsigned j;
        int unsigned fd0;
        trig = 1'b0;
        got  = 0;
        j    = 0;
        @(negedge clk);
        decim       = 16'(dec);
        trig_level  = lvl;
        trig_rising = rise;
        bp_len      = bp;
        force_trig  = 1'b0;
        arm         = 1'b1;
        fd0         = frames_done;
        @(posedge clk);
        #1;
        check("arm_to_wait", state, 1);
        forever begin
            @(negedge clk);
            arm = 1'b0;
            if (frames_done != fd0)
                break;
            if (rst_at != 0 && n_strobe >= rst_at) begin
                rst_n = 1'b0;
                @(posedge clk);
                #1;
                check("rst_state", state, 0);
                check("rst_send_n", tx_send_n, 1);
                @(negedge clk);
                rst_n = 1'b1;
                exp_q.delete();
                n_strobe = 0;
                break;
            end
            if (j >= BUDGET) begin
                total++;
                bad++;
                $display("FAIL timeout: got %0d frames expected %0d", frames_done, fd0 + 1);
                break;
            end
            v   = pattern(pat, j, dec);
            frc = (pat == 2);
            adc_in     = v;
            force_trig = frc;
            if (poke && trig && $urandom_range(0, 7) == 0)
                arm = 1'b1;
            @(posedge clk);
            if (j % (dec + 1) == dec) begin
                smp.push_back(v);
                if (!trig) begin
                    if (smp.size() >= 2 && fires(frc, rise, lvl, smp[smp.size() - 2], v)) begin
                        trig = 1'b1;
                        got  = 1;
                        if (HDR_ON)
                            exp_q.push_back(HDR);
                        exp_q.push_back(v);
                        #1;
                        check("trig_to_capture", state, 2);
                    end
                end else if (got < DEPTH) begin
                    exp_q.push_back(v);
                    got++;
                    if (got == DEPTH) begin
                        #1;
                        check("capture_end_state", state, HDR_ON ? 3 : 4);
                    end
                end
            end
            j++;
        end
        force_trig = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        adc_in      = '0;
        arm         = 1'b0;
        force_trig  = 1'b0;
        trig_level  = '0;
        trig_rising = 1'b1;
        decim       = '0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        check("reset_send_n", tx_send_n, 1);
        check("reset_data", tx_data, 0);
        check("reset_state", state, 0);
        check("reset_done", frame_done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_frame(0, 8'd128, 1'b1, 0, 0,   1'b0, 0);
        run_frame(3, 8'd128, 1'b0, 1, 2,   1'b0, 0);
        run_frame(2, 8'd128, 1'b1, 2, 0,   1'b0, 0);
        run_frame(0, 8'd128, 1'b1, 3, 100, 1'b0, 0);
        run_frame(1, 8'd90,  1'b1, 3, 3,   1'b0, 10);
        run_frame(0, 8'd128, 1'b0, 0, 1,   1'b0, 0);
        run_frame(1, 8'd128, 1'b1, 3, 2,   1'b1, 0);
        for (int i = 0; i < 5; i++) begin
            int p;
            p = $urandom_range(0, 2);
            run_frame($urandom_range(0, 3), 8'($urandom_range(40, 215)), 1'($urandom_range(0, 1)),
                      (p == 1) ? 3 : p, $urandom_range(0, 5), 1'($urandom_range(0, 1)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
